// File: rtl/mem_pkg.sv
// Shared constants, operation encoding and sizing helper for the multi-channel
// round-robin memory.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 5;
    localparam int MEM_DATA_WIDTH = 8;
    localparam int MEM_MAX_CH     = 8;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // Bits needed to hold an index in 0..n-1, never less than one so that a
    // single-channel build still has a legal vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search at the
// priority pointer, pointer moves to the channel after the last winner.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = clog2_min1(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  gnt_s;
    logic [PW-1:0] win_idx_s;
    logic          found_s;
    int            cand_s;

    // Priority search from ptr with wrap-around; no grant while in reset.
    always_comb begin
        gnt_s     = '0;
        win_idx_s = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        if (rst) begin
            found_s = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cand_s = int'(ptr_q) + i;
                if (cand_s >= N) begin
                    cand_s = cand_s - N;
                end else begin
                    cand_s = cand_s;
                end
                if (!found_s && req[cand_s]) begin
                    gnt_s[cand_s] = 1'b1;
                    win_idx_s     = PW'(cand_s);
                    found_s       = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Next pointer: one past the winner, modulo N; hold when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (found_s) begin
            if (int'(win_idx_s) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = PW'(int'(win_idx_s) + 1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/mem_rr_arb.sv
// Shared single-port RAM fronted by a round-robin arbiter; one access per clock,
// reads return one cycle after the grant tagged by a one-hot rvalid.
module mem_rr_arb
    import mem_pkg::*;
#(
    parameter int                      ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int                      DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int                      NUM_CH     = 2,
    parameter int                      WRITE_ACK  = 0,
    parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH-1:0]            we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CH-1:0]            gnt,
    output logic [NUM_CH-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = clog2_min1(NUM_CH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};

    logic [NUM_CH-1:0]     gnt_s;
    logic                  any_gnt_s;
    logic [CW-1:0]         sel_idx_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    mem_op_e               sel_op_s;

    logic [NUM_CH-1:0]     rvalid_q;
    logic [NUM_CH-1:0]     rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt_s)
    );

    // One-hot grant to channel index encoder.
    always_comb begin
        sel_idx_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_s[c]) begin
                sel_idx_s = CW'(c);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Route the winning channel's command fields to the storage port.
    always_comb begin
        any_gnt_s   = |gnt_s;
        sel_addr_s  = addr[int'(sel_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = wdata[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        sel_op_s    = mem_op_e'(we[sel_idx_s]);
    end

    // Storage write port; grant is already forced low during reset, so a
    // write coincident with reset never lands.
    always_ff @(posedge clk) begin
        if (any_gnt_s && (sel_op_s == OP_WRITE)) begin
            mem_q[sel_addr_s] <= sel_wdata_s;
        end
    end

    // Response next-state: reads load rdata, write acks only pulse rvalid.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (any_gnt_s) begin
            if (sel_op_s == OP_READ) begin
                rvalid_d = gnt_s;
                rdata_d  = mem_q[sel_addr_s];
            end else if (WRITE_ACK != 0) begin
                rvalid_d = gnt_s;
            end else begin
                rvalid_d = '0;
            end
        end else begin
            rvalid_d = '0;
        end
    end

    // Response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt    = gnt_s;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_rr_arb.sv
// Bench for mem_rr_arb: a 2-channel read-only-response instance and a
// 4-channel write-acknowledge instance checked against a behavioural model.
module tb_mem_rr_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
    logic [9:0]  addr_a;
    logic [15:0] wdata_a;
    logic [7:0]  rdata_a;

    logic [3:0]  req_b, we_b, gnt_b, rvalid_b;
    logic [19:0] addr_b;
    logic [31:0] wdata_b;
    logic [7:0]  rdata_b;

    mem_rr_arb #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .NUM_CH(2), .WRITE_ACK(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a));

    mem_rr_arb #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .NUM_CH(4), .WRITE_ACK(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b));

    // Both instances viewed through 8-channel padded vectors for the model.
    logic [7:0]  req_p [2];
    logic [7:0]  we_p  [2];
    logic [39:0] addr_p [2];
    logic [63:0] wdata_p [2];
    logic [7:0]  gnt_p [2];
    logic [7:0]  rv_p  [2];
    logic [7:0]  rd_p  [2];
    assign req_p[0] = {6'b0, req_a};    assign req_p[1] = {4'b0, req_b};
    assign we_p[0]  = {6'b0, we_a};     assign we_p[1]  = {4'b0, we_b};
    assign addr_p[0] = {30'b0, addr_a}; assign addr_p[1] = {20'b0, addr_b};
    assign wdata_p[0] = {48'b0, wdata_a}; assign wdata_p[1] = {32'b0, wdata_b};
    assign gnt_p[0] = {6'b0, gnt_a};    assign gnt_p[1] = {4'b0, gnt_b};
    assign rv_p[0]  = {6'b0, rvalid_a}; assign rv_p[1]  = {4'b0, rvalid_b};
    assign rd_p[0]  = rdata_a;          assign rd_p[1]  = rdata_b;

    int checks = 0;
    int passes = 0;

    int         m_nch [2] = '{2, 4};
    bit         m_wack [2] = '{1'b0, 1'b1};
    int         m_ptr [2];
    logic [7:0] m_mem [2][32];
    logic [7:0] m_rv [2];
    logic [7:0] m_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Winner under the round-robin rule: first requester from ptr upward, wrapping.
    function automatic int model_gnt(input int k);
        if (rst) return -1;
        for (int i = 0; i < m_nch[k]; i++) begin
            int c;
            c = (m_ptr[k] + i) % m_nch[k];
            if (req_p[k][c]) return c;
        end
        return -1;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            m_rv[k]  = 8'h00;
            m_rd[k]  = 8'h00;
            for (int a = 0; a < 32; a++) m_mem[k][a] = 8'h00;
        end
    end

    // Model state advance at each clock edge or reset assertion.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ptr[k] = 0;
                m_rv[k]  = 8'h00;
                m_rd[k]  = 8'h00;
            end else begin
                int g;
                int a;
                g = model_gnt(k);
                m_rv[k] = 8'h00;
                if (g >= 0) begin
                    a = int'(addr_p[k][g*5 +: 5]);
                    if (we_p[k][g]) begin
                        m_mem[k][a] = wdata_p[k][g*8 +: 8];
                        if (m_wack[k]) m_rv[k] = 8'd1 << g;
                    end else begin
                        m_rd[k] = m_mem[k][a];
                        m_rv[k] = 8'd1 << g;
                    end
                    m_ptr[k] = (g + 1) % m_nch[k];
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            logic [7:0] eg;
            g  = model_gnt(k);
            eg = (g >= 0) ? (8'd1 << g) : 8'd0;
            chk($sformatf("model_gnt[%0d]", k), {24'b0, gnt_p[k]}, {24'b0, eg});
            chk($sformatf("model_rvalid[%0d]", k), {24'b0, rv_p[k]}, {24'b0, m_rv[k]});
            chk($sformatf("model_rdata[%0d]", k), {24'b0, rd_p[k]}, {24'b0, m_rd[k]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [1:0] exp_rr2 [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [3:0] exp_rr4 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;

        // Reset: no grant even with requests, outputs cleared.
        cyc();
        req_a = 2'b11;
        #4;
        chk("rst_gnt", {30'b0, gnt_a}, 32'h0);
        chk("rst_rvalid", {30'b0, rvalid_a}, 32'h0);
        chk("rst_rdata", {24'b0, rdata_a}, 32'h0);
        cyc();
        rst = 1'b0; req_a = 2'b01; addr_a[4:0] = 5'h07;
        #4;
        chk("gnt_after_rst", {30'b0, gnt_a}, 32'h1);
        cyc();
        req_a = 2'b00;
        #4;
        chk("init_rvalid", {30'b0, rvalid_a}, 32'h1);
        chk("init_rdata", {24'b0, rdata_a}, 32'h0);
        cyc();

        // Single channel write then read of the same word.
        req_a = 2'b01; we_a = 2'b01; addr_a[4:0] = 5'h0A; wdata_a[7:0] = 8'h5C;
        cyc();
        we_a = 2'b00;
        #4;
        chk("no_write_ack", {30'b0, rvalid_a}, 32'h0);
        cyc();
        req_a = 2'b00;
        #4;
        chk("rd_rvalid", {30'b0, rvalid_a}, 32'h1);
        chk("rd_rdata", {24'b0, rdata_a}, 32'h5C);
        cyc();

        // Bring ptr back to 0, then both channels hold requests.
        req_a = 2'b10; addr_a[9:5] = 5'h00;
        cyc();
        req_a = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #4;
            chk($sformatf("rr2_gnt%0d", i), {30'b0, gnt_a}, {30'b0, exp_rr2[i]});
            cyc();
        end
        req_a = 2'b00;

        // Contention: ch0 writes addr 3 while ch1 reads it.
        req_a = 2'b11; we_a = 2'b01; addr_a = {5'h03, 5'h03}; wdata_a[7:0] = 8'hA5;
        #4;
        chk("raw_gnt0", {30'b0, gnt_a}, 32'h1);
        cyc();
        req_a = 2'b10; we_a = 2'b00;
        #4;
        chk("raw_gnt1", {30'b0, gnt_a}, 32'h2);
        cyc();
        req_a = 2'b00;
        #4;
        chk("raw_rvalid", {30'b0, rvalid_a}, 32'h2);
        chk("raw_rdata", {24'b0, rdata_a}, 32'hA5);
        cyc();

        // Four channels all requesting rotate 0,1,2,3,0.
        req_b = 4'b1111; we_b = 4'b0000; addr_b = {5'd3, 5'd2, 5'd1, 5'd0};
        for (int i = 0; i < 5; i++) begin
            #4;
            chk($sformatf("rr4_gnt%0d", i), {28'b0, gnt_b}, {28'b0, exp_rr4[i]});
            cyc();
        end
        req_b = 4'b0000;

        // Write acknowledge: ack leaves rdata untouched.
        req_b = 4'b0100; we_b = 4'b0100; addr_b[14:10] = 5'h04; wdata_b[23:16] = 8'h3C;
        cyc();
        we_b = 4'b0000;
        #4;
        chk("wack2_rvalid", {28'b0, rvalid_b}, 32'h4);
        chk("wack2_rdata", {24'b0, rdata_b}, 32'h0);
        cyc();
        req_b = 4'b0000;
        #4;
        chk("rd4_rdata", {24'b0, rdata_b}, 32'h3C);
        cyc();
        req_b = 4'b0010; we_b = 4'b0010; addr_b[9:5] = 5'h1F; wdata_b[15:8] = 8'hFF;
        #4;
        chk("wack1_gnt", {28'b0, gnt_b}, 32'h2);
        cyc();
        we_b = 4'b0000;
        #4;
        chk("wack1_rvalid", {28'b0, rvalid_b}, 32'h2);
        chk("wack1_rdata_held", {24'b0, rdata_b}, 32'h3C);
        cyc();
        req_b = 4'b0000;
        #4;
        chk("rd31_rvalid", {28'b0, rvalid_b}, 32'h2);
        chk("rd31_rdata", {24'b0, rdata_b}, 32'hFF);
        cyc();

        // Reset after a read grant: response dropped, write under reset ignored.
        req_a = 2'b01; we_a = 2'b00; addr_a[4:0] = 5'h0A;
        cyc();
        rst = 1'b1; we_a = 2'b01; wdata_a[7:0] = 8'h00;
        #4;
        chk("midrst_rvalid", {30'b0, rvalid_a}, 32'h0);
        chk("midrst_rdata", {24'b0, rdata_a}, 32'h0);
        chk("midrst_gnt", {30'b0, gnt_a}, 32'h0);
        cyc();
        rst = 1'b0; req_a = 2'b11; we_a = 2'b00; addr_a = {5'h03, 5'h0A};
        #4;
        chk("post_rst_ptr", {30'b0, gnt_a}, 32'h1);
        cyc();
        req_a = 2'b10;
        #4;
        chk("post_rst_rdata0", {24'b0, rdata_a}, 32'h5C);
        cyc();
        req_a = 2'b00;
        #4;
        chk("post_rst_rvalid1", {30'b0, rvalid_a}, 32'h2);
        chk("post_rst_rdata1", {24'b0, rdata_a}, 32'hA5);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
